// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the EX stage: latency-modelled
// multiply, 32-step restoring divide, pipeline stall and one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for a mul/div request from EX
// MUL   | multiply in flight, counting down MUL_LAT cycles
// DIV   | restoring divide, one quotient bit per cycle
// DONE  | hi/lo hold a fresh result; done pulses, start ignored
module muldiv_seq #(
  parameter int MUL_LAT   = 2,
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op,
  input  logic        is_sign,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        cancel,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [5:0] CNT_MUL = 6'(MUL_LAT - 1);
  localparam logic [5:0] CNT_DIV = 6'(DIV_ITERS - 1);

  state_t      r_state, w_state_nxt;
  logic [5:0]  r_cnt;
  logic [31:0] r_op_a;   // multiplicand, or dividend magnitude shifting into quotient
  logic [31:0] r_op_b;   // multiplier, or divisor magnitude
  logic [31:0] r_rem;
  logic        r_sign;
  logic        r_sign_a;
  logic        r_sign_b;

  logic        w_neg_a, w_neg_b;
  logic [31:0] w_mag_a, w_mag_b;
  logic [32:0] w_shift, w_diff;
  logic        w_no_borrow;
  logic [31:0] w_rem_step, w_quo_step;
  logic [63:0] w_ext_a, w_ext_b, w_prod;

  assign w_neg_a = is_sign & src_a[31];
  assign w_neg_b = is_sign & src_b[31];
  assign w_mag_a = w_neg_a ? (~src_a + 32'd1) : src_a;
  assign w_mag_b = w_neg_b ? (~src_b + 32'd1) : src_b;

  assign w_shift     = {r_rem, r_op_a[31]};
  assign w_diff      = w_shift - {1'b0, r_op_b};
  assign w_no_borrow = ~w_diff[32];
  assign w_rem_step  = w_no_borrow ? w_diff[31:0] : w_shift[31:0];
  assign w_quo_step  = {r_op_a[30:0], w_no_borrow};

  // Low 64 bits of a sign-extended product are correct for both signednesses.
  assign w_ext_a = {{32{r_sign & r_op_a[31]}}, r_op_a};
  assign w_ext_b = {{32{r_sign & r_op_b[31]}}, r_op_b};
  assign w_prod  = w_ext_a * w_ext_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    stall       = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !cancel) begin
          stall = 1'b1;
          if (!op)               w_state_nxt = S_MUL;
          else if (src_b == '0)  w_state_nxt = S_DONE;
          else                   w_state_nxt = S_DIV;
        end
      end
      S_MUL, S_DIV: begin
        stall = 1'b1;
        busy  = 1'b1;
        if (cancel)             w_state_nxt = S_IDLE;
        else if (r_cnt == '0)   w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_rem    <= '0;
      r_sign   <= 1'b0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !cancel) begin
            if (!op) begin
              r_op_a <= src_a;
              r_op_b <= src_b;
              r_sign <= is_sign;
              r_cnt  <= CNT_MUL;
            end else if (src_b != '0) begin
              r_op_a   <= w_mag_a;
              r_op_b   <= w_mag_b;
              r_rem    <= '0;
              r_sign_a <= w_neg_a;
              r_sign_b <= w_neg_b;
              r_cnt    <= CNT_DIV;
            end else begin
              hi <= src_a;
              lo <= '1;
            end
          end
        end
        S_MUL: begin
          if (r_cnt != '0)  r_cnt <= r_cnt - 6'd1;
          else if (!cancel) {hi, lo} <= w_prod;
        end
        S_DIV: begin
          r_rem  <= w_rem_step;
          r_op_a <= w_quo_step;
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 6'd1;
          end else if (!cancel) begin
            hi <= r_sign_a              ? (~w_rem_step + 32'd1) : w_rem_step;
            lo <= (r_sign_a ^ r_sign_b) ? (~w_quo_step + 32'd1) : w_quo_step;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
